// File: rtl/counter_mod.sv
// Bounded up/down counter with per-cycle step, limit, and saturate-or-wrap control.
// Optional sticky overflow/underflow flags are enabled by defining COUNTER_MOD_STICKY_EN.
module counter_mod #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              tc
`ifdef COUNTER_MOD_STICKY_EN
    ,
    input  logic              clr_sticky,
    output logic              ovf_sticky,
    output logic              unf_sticky
`endif
);

    // One extra bit so that limit = 2^WIDTH-1 keeps its carry.
    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] ONE_X = XW'(1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_mod: WIDTH must be in 2..32");
        end
        if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step_w
            $error("counter_mod: STEP_W must be in 1..WIDTH");
        end
    endgenerate

    function automatic logic up_crosses(input logic [XW-1:0] cnt,
                                        input logic [XW-1:0] s,
                                        input logic [XW-1:0] lim);
        return (cnt + s) > lim;
    endfunction

    function automatic logic down_crosses(input logic [XW-1:0] cnt,
                                          input logic [XW-1:0] s);
        return s > cnt;
    endfunction

    function automatic logic [WIDTH-1:0] bound_up(input logic [XW-1:0] cnt,
                                                  input logic [XW-1:0] s,
                                                  input logic [XW-1:0] lim,
                                                  input logic          sat);
        logic [XW-1:0] r;
        r = cnt + s;
        if (r > lim) begin
            r = sat ? lim : (r - (lim + ONE_X));
        end
        return WIDTH'(r);
    endfunction

    function automatic logic [WIDTH-1:0] bound_down(input logic [XW-1:0] cnt,
                                                    input logic [XW-1:0] s,
                                                    input logic [XW-1:0] lim,
                                                    input logic          sat);
        logic [XW-1:0] r;
        if (s <= cnt) begin
            r = cnt - s;
        end else if (sat) begin
            r = '0;
        end else begin
            r = cnt + lim + ONE_X - s;
        end
        return WIDTH'(r);
    endfunction

    logic [WIDTH-1:0] count_p0;
    logic             tc_p0;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    lim_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    eff_step;
    logic [WIDTH-1:0] load_val;

    assign cnt_x    = XW'(count_p0);
    assign lim_x    = XW'(limit);
    assign step_x   = XW'(step);
    assign eff_step = (step_x < lim_x) ? step_x : lim_x;
    assign load_val = (data_load > limit) ? limit : data_load;

    always_comb begin
        count_nxt = count_p0;
        tc_nxt    = 1'b0;
        if (!load_n) begin
            count_nxt = load_val;
        end else if (ce) begin
            // A runtime limit drop can leave the count stranded above the range.
            if (cnt_x > lim_x) begin
                count_nxt = sat_mode ? limit : '0;
                tc_nxt    = 1'b1;
            end else if (eff_step != '0) begin
                if (up_down) begin
                    count_nxt = bound_up(cnt_x, eff_step, lim_x, sat_mode);
                    tc_nxt    = up_crosses(cnt_x, eff_step, lim_x);
                end else begin
                    count_nxt = bound_down(cnt_x, eff_step, lim_x, sat_mode);
                    tc_nxt    = down_crosses(cnt_x, eff_step);
                end
            end
        end
    end

    // Stage p0: count and terminal-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p0 <= '0;
            tc_p0    <= 1'b0;
        end else begin
            count_p0 <= count_nxt;
            tc_p0    <= tc_nxt;
        end
    end

    assign count_out = count_p0;
    assign tc        = tc_p0;
    assign max_count = (count_p0 == limit);
    assign zero      = (count_p0 == '0);

`ifdef COUNTER_MOD_STICKY_EN
    // Direction of the terminal event decides which flag is set; set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            if (tc_nxt && up_down) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (tc_nxt && !up_down) begin
                unf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                unf_sticky <= 1'b0;
            end
        end
    end
`endif

endmodule
